// File: rtl/acc_cpu_core.sv
// Accumulator CPU: fetch/decode/execute over a synchronous single-port memory.
// Latency: LDA/ADD/AND 6 cycles, NOT/INC/STA 4, JMP 3, HLT reaches HALT 3 after its fetch.
// No backpressure: memory is assumed to answer every read on the following cycle.
module acc_cpu_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] ac_out,
    output logic              e_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              busy,
    output logic              halted
);

    if (DATA_W < ADDR_W + 3) begin : g_bad_width
        $error("acc_cpu_core: DATA_W must be at least ADDR_W+3");
    end

    localparam logic [2:0] OP_LDA = 3'b000;
    localparam logic [2:0] OP_STA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_INC = 3'b101;
    localparam logic [2:0] OP_JMP = 3'b110;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_LOADIR, S_DECODE, S_MREAD,
        S_MLOAD, S_EXEC, S_STORE, S_HALT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] ar;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] dr;
    logic [DATA_W-1:0] ac;
    logic              e;

    logic [2:0]        opcode;
    logic [ADDR_W-1:0] ir_addr;
    logic              ir_unused;

    assign opcode    = ir[DATA_W-1 -: 3];
    assign ir_addr   = ir[ADDR_W-1:0];
    assign ir_unused = ^ir;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= '0;
            ar    <= '0;
            ir    <= '0;
            dr    <= '0;
            ac    <= '0;
            e     <= 1'b0;
        end else begin
            case (state)
                S_IDLE:   if (start) state <= S_FETCH;
                S_FETCH:  state <= S_LOADIR;
                S_LOADIR: begin
                    ir    <= mem_rdata;
                    pc    <= pc + ADDR_W'(1);
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    ar <= ir_addr;
                    case (opcode)
                        OP_LDA, OP_ADD, OP_AND: state <= S_MREAD;
                        OP_NOT, OP_INC:         state <= S_EXEC;
                        OP_STA:                 state <= S_STORE;
                        OP_JMP: begin
                            pc    <= ir_addr;
                            state <= S_FETCH;
                        end
                        default:                state <= S_HALT;
                    endcase
                end
                S_MREAD:  state <= S_MLOAD;
                S_MLOAD: begin
                    dr    <= mem_rdata;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    // E is only ever written by the two arithmetic opcodes
                    case (opcode)
                        OP_LDA:  ac <= dr;
                        OP_ADD:  {e, ac} <= {1'b0, ac} + {1'b0, dr};
                        OP_AND:  ac <= ac & dr;
                        OP_NOT:  ac <= ~ac;
                        OP_INC:  {e, ac} <= {1'b0, ac} + (DATA_W+1)'(1);
                        default: ;
                    endcase
                    state <= S_FETCH;
                end
                S_STORE:  state <= S_FETCH;
                S_HALT:   state <= S_HALT;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Strobes are gated by rst_n so a reset landing on STORE never writes
    always_comb begin
        mem_addr  = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            S_FETCH: begin
                mem_addr = pc;
                mem_re   = rst_n;
            end
            S_MREAD: begin
                mem_addr = ar;
                mem_re   = rst_n;
            end
            S_STORE: begin
                mem_addr  = ar;
                mem_we    = rst_n;
                mem_wdata = ac;
            end
            default: ;
        endcase
    end

    assign ac_out = ac;
    assign e_out  = e;
    assign pc_out = pc;
    assign busy   = (state != S_IDLE) && (state != S_HALT);
    assign halted = (state == S_HALT);

endmodule

// File: tb/tb_acc_cpu_core.sv
// Bench for acc_cpu_core: single-instruction vector table plus program-level sequences,
// with an 8/4 instance and a 12/8 instance each backed by a synchronous memory model.
module tb_acc_cpu_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit data / 4-bit address instance
    logic       rst_n, start, mem_re, mem_we, e_out, busy, halted;
    logic [3:0] mem_addr, pc_out;
    logic [7:0] mem_wdata, mem_rdata, ac_out;
    logic [7:0] mem [16];
    logic       ld_we;
    logic [3:0] ld_addr;
    logic [7:0] ld_dat;

    acc_cpu_core #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .ac_out(ac_out), .e_out(e_out), .pc_out(pc_out), .busy(busy), .halted(halted)
    );

    always @(posedge clk) begin
        if (ld_we) mem[ld_addr] <= ld_dat;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    // 12-bit data / 8-bit address instance
    logic        rst12_n, start12, re12, we12, e12, busy12, halted12;
    logic [7:0]  addr12, pc12;
    logic [11:0] wdata12, rdata12, ac12;
    logic [11:0] mem12 [256];
    logic        ld12_we;
    logic [7:0]  ld12_addr;
    logic [11:0] ld12_dat;

    acc_cpu_core #(.DATA_W(12), .ADDR_W(8)) dut12 (
        .clk(clk), .rst_n(rst12_n), .start(start12), .mem_rdata(rdata12),
        .mem_addr(addr12), .mem_re(re12), .mem_we(we12), .mem_wdata(wdata12),
        .ac_out(ac12), .e_out(e12), .pc_out(pc12), .busy(busy12), .halted(halted12)
    );

    always @(posedge clk) begin
        if (ld12_we) mem12[ld12_addr] <= ld12_dat;
        else if (we12) mem12[addr12] <= wdata12;
        if (re12) rdata12 <= mem12[addr12];
    end

    int checks = 0;
    int errors = 0;
    int strobe_err = 0;

    always @(negedge clk) begin
        if (mem_re && mem_we) strobe_err++;
        if (!busy && (mem_re || mem_we)) strobe_err++;
        if (re12 && we12) strobe_err++;
        if (!busy12 && (re12 || we12)) strobe_err++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset8;
        rst_n = 1'b0;
        start = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic load8(input logic [3:0] a, input logic [7:0] d);
        ld_we = 1'b1; ld_addr = a; ld_dat = d;
        tick;
        ld_we = 1'b0;
    endtask

    task automatic load12(input logic [7:0] a, input logic [11:0] d);
        ld12_we = 1'b1; ld12_addr = a; ld12_dat = d;
        tick;
        ld12_we = 1'b0;
    endtask

    task automatic pulse8;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_halt8(input int maxc, output int cyc);
        cyc = 0;
        while (!halted && cyc < maxc) begin
            tick;
            cyc++;
        end
        chk("halt_reached", 32'(halted), 32'd1);
    endtask

    task automatic wait_fetch8(input logic [3:0] a, input int maxc, output bit ok);
        int n;
        ok = 1'b0;
        n = 0;
        while (!ok && n < maxc) begin
            tick;
            n++;
            if (mem_re && mem_addr == a) ok = 1'b1;
        end
    endtask

    typedef struct {
        logic [7:0] instr;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_ac;
        logic       exp_e;
        int         exp_lat;
        logic [3:0] exp_pc;
        logic [7:0] exp_m9;
    } vec_t;

    vec_t vecs [13];
    vec_t exp_q [$];

    initial begin
        vec_t ev;
        bit   ok;
        int   cyc, lat;

        rst_n = 1'b0; start = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_dat = '0;
        rst12_n = 1'b0; start12 = 1'b0; ld12_we = 1'b0; ld12_addr = '0; ld12_dat = '0;

        // program: LDA 8 (AC=a), <instr>, HLT, HLT ; mem[8]=a, mem[9]=b
        vecs[0]  = '{8'h09, 8'h33, 8'h5A, 8'h5A, 1'b0, 6, 4'h3, 8'h5A}; // LDA 9
        vecs[1]  = '{8'h49, 8'h90, 8'h80, 8'h10, 1'b1, 6, 4'h3, 8'h80}; // ADD carry
        vecs[2]  = '{8'h49, 8'h12, 8'h34, 8'h46, 1'b0, 6, 4'h3, 8'h34}; // ADD
        vecs[3]  = '{8'h49, 8'hFF, 8'h01, 8'h00, 1'b1, 6, 4'h3, 8'h01}; // ADD wrap
        vecs[4]  = '{8'h69, 8'hF0, 8'h3C, 8'h30, 1'b0, 6, 4'h3, 8'h3C}; // AND
        vecs[5]  = '{8'h80, 8'h0F, 8'h00, 8'hF0, 1'b0, 4, 4'h3, 8'h00}; // NOT
        vecs[6]  = '{8'hA0, 8'hFF, 8'h00, 8'h00, 1'b1, 4, 4'h3, 8'h00}; // INC wrap
        vecs[7]  = '{8'hA0, 8'h7F, 8'h00, 8'h80, 1'b0, 4, 4'h3, 8'h00}; // INC
        vecs[8]  = '{8'h29, 8'hC3, 8'h11, 8'hC3, 1'b0, 4, 4'h3, 8'hC3}; // STA 9
        vecs[9]  = '{8'hC3, 8'h55, 8'h00, 8'h55, 1'b0, 3, 4'h4, 8'h00}; // JMP 3
        vecs[10] = '{8'hE0, 8'h66, 8'h00, 8'h66, 1'b0, 3, 4'h2, 8'h00}; // HLT
        vecs[11] = '{8'h19, 8'h21, 8'h9C, 8'h9C, 1'b0, 6, 4'h3, 8'h9C}; // LDA, bit4 ignored
        vecs[12] = '{8'h9F, 8'hA5, 8'h00, 8'h5A, 1'b0, 4, 4'h3, 8'h00}; // NOT, addr ignored

        // reset state
        reset8;
        chk("rst_ac", 32'(ac_out), 32'h0);
        chk("rst_e", 32'(e_out), 32'h0);
        chk("rst_pc", 32'(pc_out), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_strobes", 32'({mem_re, mem_we}), 32'h0);

        foreach (vecs[i]) begin
            reset8;
            load8(4'h0, 8'h08);
            load8(4'h1, vecs[i].instr);
            load8(4'h2, 8'hE0);
            load8(4'h3, 8'hE0);
            load8(4'h8, vecs[i].a);
            load8(4'h9, vecs[i].b);
            exp_q.push_back(vecs[i]);
            pulse8;
            wait_fetch8(4'h1, 20, ok);
            chk($sformatf("v%0d_fetch1", i), 32'(ok), 32'd1);
            lat = 0;
            while (!(halted || (mem_re && (mem_addr == 4'h2 || mem_addr == 4'h3))) && lat < 20) begin
                tick;
                lat++;
            end
            wait_halt8(40, cyc);
            ev = exp_q.pop_front();
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(ev.exp_lat));
            chk($sformatf("v%0d_ac", i), 32'(ac_out), 32'(ev.exp_ac));
            chk($sformatf("v%0d_e", i), 32'(e_out), 32'(ev.exp_e));
            chk($sformatf("v%0d_pc", i), 32'(pc_out), 32'(ev.exp_pc));
            chk($sformatf("v%0d_mem9", i), 32'(mem[9]), 32'(ev.exp_m9));
        end

        // LDA A / ADD B / STA C / HLT, 19 cycles first fetch to halt
        reset8;
        load8(4'h0, 8'h0A); load8(4'h1, 8'h4B); load8(4'h2, 8'h2C); load8(4'h3, 8'hE0);
        load8(4'hA, 8'h90); load8(4'hB, 8'h80); load8(4'hC, 8'h00);
        pulse8;
        chk("prog_first_fetch", 32'({mem_re, mem_addr}), 32'({1'b1, 4'h0}));
        wait_halt8(40, cyc);
        chk("prog_cycles", 32'(cyc), 32'd19);
        chk("prog_memc", 32'(mem[12]), 32'h10);
        chk("prog_ac", 32'(ac_out), 32'h10);
        chk("prog_e", 32'(e_out), 32'h1);
        chk("prog_busy", 32'(busy), 32'h0);

        // JMP 5 / INC / HLT
        reset8;
        load8(4'h0, 8'hC5); load8(4'h5, 8'hA0); load8(4'h6, 8'hE0);
        pulse8;
        wait_halt8(40, cyc);
        chk("jmp_ac", 32'(ac_out), 32'h01);
        chk("jmp_e", 32'(e_out), 32'h0);
        chk("jmp_pc", 32'(pc_out), 32'h7);

        // JMP F / INC loop: PC wraps F->0, AC wraps after 256 INCs
        reset8;
        load8(4'h0, 8'hCF); load8(4'hF, 8'hA0);
        pulse8;
        for (int k = 1; k <= 256; k++) begin
            wait_fetch8(4'hF, 20, ok);
            chk("loop_fetch_f", 32'(ok), 32'd1);
            wait_fetch8(4'h0, 20, ok);
            chk("loop_fetch_0", 32'(ok), 32'd1);
            if (k == 1) chk("loop_pc_wrap", 32'(pc_out), 32'h0);
            chk($sformatf("loop_ac_%0d", k), 32'(ac_out), 32'(k % 256));
            chk($sformatf("loop_e_%0d", k), 32'(e_out), (k == 256) ? 32'd1 : 32'd0);
        end

        // reset landing on STORE
        reset8;
        load8(4'h0, 8'h08); load8(4'h1, 8'h29); load8(4'h2, 8'hE0);
        load8(4'h8, 8'h5A); load8(4'h9, 8'h77);
        pulse8;
        cyc = 0;
        while (!mem_we && cyc < 30) begin
            tick;
            cyc++;
        end
        chk("st_reached", 32'(mem_we), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("st_rst_we", 32'(mem_we), 32'h0);
        chk("st_rst_re", 32'(mem_re), 32'h0);
        tick;
        chk("st_mem9", 32'(mem[9]), 32'h77);
        chk("st_regs", 32'({ac_out, e_out, pc_out}), 32'h0);
        chk("st_idle", 32'({busy, halted}), 32'h0);
        rst_n = 1'b1;
        pulse8;
        chk("st_rerun_pc0", 32'({mem_re, mem_addr}), 32'({1'b1, 4'h0}));
        wait_halt8(40, cyc);
        chk("st_rerun_mem9", 32'(mem[9]), 32'h5A);
        chk("st_rerun_ac", 32'(ac_out), 32'h5A);
        chk("st_rerun_pc", 32'(pc_out), 32'h3);

        // NOT keeps E; start held high through the run and in HALT
        reset8;
        load8(4'h0, 8'h08); load8(4'h1, 8'h49); load8(4'h2, 8'h80); load8(4'h3, 8'hE0);
        load8(4'h8, 8'hFF); load8(4'h9, 8'h10);
        start = 1'b1;
        tick;
        wait_halt8(40, cyc);
        chk("not_cycles", 32'(cyc), 32'd19);
        chk("not_ac", 32'(ac_out), 32'hF0);
        chk("not_e", 32'(e_out), 32'h1);
        for (int i = 0; i < 10; i++) tick;
        chk("halt_sticky", 32'({halted, busy}), 32'({1'b1, 1'b0}));
        chk("halt_pc", 32'(pc_out), 32'h4);
        chk("halt_ac", 32'(ac_out), 32'hF0);
        start = 1'b0;

        // 12-bit data, 8-bit address
        rst12_n = 1'b0;
        tick;
        tick;
        rst12_n = 1'b1;
        chk("w12_rst_ac", 32'(ac12), 32'h0);
        load12(8'h00, 12'h00A); load12(8'h01, 12'h40B); load12(8'h02, 12'h20C);
        load12(8'h03, 12'hE00); load12(8'h0A, 12'h900); load12(8'h0B, 12'h800);
        load12(8'h0C, 12'h000);
        start12 = 1'b1;
        tick;
        start12 = 1'b0;
        chk("w12_first_fetch", 32'({re12, addr12}), 32'({1'b1, 8'h00}));
        cyc = 0;
        while (!halted12 && cyc < 40) begin
            tick;
            cyc++;
        end
        chk("w12_cycles", 32'(cyc), 32'd19);
        chk("w12_memc", 32'(mem12[12]), 32'h100);
        chk("w12_ac", 32'(ac12), 32'h100);
        chk("w12_e", 32'(e12), 32'h1);
        chk("w12_pc", 32'(pc12), 32'h04);

        chk("strobe_rules", 32'(strobe_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_cpu_core.md
ACC_CPU_CORE -- requirements
Module: acc_cpu_core

Interface
REQ-001 Parameter DATA_W, default 8, data path width (AC, DR, IR, memory data).
REQ-002 Parameter ADDR_W, default 4, address width (PC, AR, memory address); elaboration SHALL fail if DATA_W < ADDR_W+3.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 start  input  1  level; begins execution from IDLE.
REQ-006 mem_addr  output  ADDR_W  memory address (PC in FETCH, AR in MREAD/STORE, else 0).
REQ-007 mem_re  output  1  read strobe; mem_rdata valid on the cycle after mem_re=1.
REQ-008 mem_we  output  1  write strobe; write mem_wdata to mem_addr at the rising edge.
REQ-009 mem_wdata  output  DATA_W  equals AC in STORE, else 0.
REQ-010 mem_rdata  input  DATA_W  synchronous memory read data.
REQ-011 ac_out  output  DATA_W  accumulator value; e_out  output  1  carry flag E; pc_out  output  ADDR_W  PC value.
REQ-012 busy  output  1  high in any state except IDLE and HALT; halted  output  1  high only in HALT.

Function
REQ-013 Instruction format: opcode = IR[DATA_W-1:DATA_W-3], address = IR[ADDR_W-1:0]; other bits ignored.
REQ-014 Opcodes: 000 LDA, 001 STA, 010 ADD, 011 AND, 100 NOT, 101 INC, 110 JMP, 111 HLT.
REQ-015 States: IDLE, FETCH, LOADIR, DECODE, MREAD, MLOAD, EXEC, STORE, HALT.
REQ-016 IDLE: start=1 -> FETCH; else stay.
REQ-017 FETCH: mem_re=1, mem_addr=PC -> LOADIR.
REQ-018 LOADIR: IR <= mem_rdata, PC <= PC+1 modulo 2^ADDR_W -> DECODE.
REQ-019 DECODE: AR <= IR address; LDA/ADD/AND -> MREAD; NOT/INC -> EXEC; STA -> STORE; JMP: PC <= IR address -> FETCH; HLT -> HALT.
REQ-020 MREAD: mem_re=1, mem_addr=IR address -> MLOAD; MLOAD: DR <= mem_rdata -> EXEC.
REQ-021 EXEC -> FETCH; LDA: AC <= DR; ADD: {E,AC} <= AC+DR (DATA_W+1-bit sum); AND: AC <= AC & DR; NOT: AC <= ~AC; INC: {E,AC} <= AC+1.
REQ-022 E SHALL change only on ADD and INC; AC wrap (e.g. all-ones +1) yields AC=0, E=1.
REQ-023 STORE: mem_we=1, mem_addr=AR, mem_wdata=AC -> FETCH.
REQ-024 HALT: terminal; stays until rst_n=0; start ignored.
REQ-025 start SHALL be ignored in every state except IDLE.
REQ-026 Latency per instruction (FETCH to next FETCH): LDA/ADD/AND 6 cycles, NOT/INC 4, STA 4, JMP 3; HLT reaches HALT 3 cycles after its FETCH.
REQ-027 mem_re, mem_we SHALL never be high simultaneously; both SHALL be 0 outside FETCH/MREAD/STORE.

Reset
REQ-028 rst_n=0 at a rising edge: state <= IDLE, PC, AR, IR, DR, AC <= 0, E <= 0.
REQ-029 mem_re, mem_we SHALL be 0 combinationally in any cycle with rst_n=0 (no write if reset hits STORE).
REQ-030 Reset SHALL take priority over start and over any in-flight instruction; no partial register update survives.

Verification (DATA_W=8, ADDR_W=4 unless stated)
REQ-031 mem[0..3]=0x0A,0x4B,0x2C,0xE0, mem[A]=0x90, mem[B]=0x80, pulse start -> mem[C]=0x10, AC=0x10, E=1, halted=1 exactly 19 cycles after first FETCH.
REQ-032 mem[0]=0xC5 (JMP 5), mem[5]=0xA0 (INC), mem[6]=0xE0 -> AC=0x01, E=0, pc_out=0x7, halted=1.
REQ-033 mem[0]=0xCF, mem[F]=0xA0 -> pc_out wraps 0xF->0x0; after 256 INCs AC=0x00 and E=1 on the wrapping INC.
REQ-034 rst_n=0 during a STORE cycle -> mem_we=0 that cycle, target memory unchanged, all registers 0, state IDLE; start re-runs from PC=0.
REQ-035 AC=0x0F with E=1, execute NOT -> AC=0xF0, E=1 unchanged; start pulsed while busy or halted -> no effect.
REQ-036 DATA_W=12, ADDR_W=8: opcode from IR[11:9], 8-bit address; rerun REQ-031 program scaled -> identical results with 12-bit AC.
